// File: rtl/rom_shadow_copier.sv
`default_nettype none
// ============================================================================
//  Module   : rom_shadow_copier
//  Purpose  : Copies ROM_LEN bytes from a synchronous boot ROM into SRAM,
//             starting at SRAM_BASE. Each byte takes a FETCH, a LATCH and
//             one or more WRITE cycles. The WRITE state lasts until the SRAM
//             acknowledges the write.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             start, abort      - copy request pulse / early-stop level
//             rom_a, rom_dout   - ROM address out, ROM data in (1-cycle read)
//             sram_a, sram_din  - SRAM write address / data
//             sram_req,sram_ack - write handshake (req held until ack)
//             busy, cpu_wait    - copy in progress (identical)
//             done, aborted     - sticky outcome of the last copy
//  Revision : 1.0 - initial release
// ============================================================================
module rom_shadow_copier #(
  parameter int          ROM_LEN   = 9216,
  parameter logic [20:0] SRAM_BASE = 21'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [13:0] rom_a,
  input  logic [7:0]  rom_dout,
  output logic [20:0] sram_a,
  output logic [7:0]  sram_din,
  output logic        sram_req,
  input  logic        sram_ack,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        cpu_wait
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_LATCH = 3'd2;
  localparam logic [2:0] c_WRITE = 3'd3;
  localparam logic [2:0] c_FIN   = 3'd4;

  localparam logic [13:0] c_LAST = 14'(ROM_LEN - 1);

  logic [2:0]  r_state;
  logic [13:0] r_idx;
  logic [13:0] r_rom_a;
  logic [20:0] r_sram_a;
  logic [7:0]  r_sram_din;
  logic        r_sram_req;
  logic        r_busy;
  logic        r_done;
  logic        r_aborted;

  // Destination address; the 21-bit add wraps naturally at the top of SRAM.
  logic [20:0] w_sram_a;
  // Abort is only acted upon while no write is outstanding.
  logic        w_abort_now;
  logic        w_last;

  assign w_sram_a    = SRAM_BASE + {7'd0, r_idx};
  assign w_abort_now = abort && ((r_state == c_FETCH) || (r_state == c_LATCH));
  assign w_last      = (r_idx == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_idx      <= 14'd0;
      r_rom_a    <= 14'd0;
      r_sram_a   <= 21'd0;
      r_sram_din <= 8'd0;
      r_sram_req <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else if (w_abort_now) begin
      // Sticky abort outcome; the next accepted start clears it again.
      r_state   <= c_IDLE;
      r_busy    <= 1'b0;
      r_aborted <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          // A start accompanied by abort is treated as no request at all.
          if (start && !abort) begin
            r_state   <= c_FETCH;
            r_idx     <= 14'd0;
            r_rom_a   <= 14'd0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
          end
        end
        c_FETCH: begin
          // rom_a was loaded on entry; the ROM returns data next cycle.
          r_state <= c_LATCH;
        end
        c_LATCH: begin
          r_sram_din <= rom_dout;
          r_sram_a   <= w_sram_a;
          r_sram_req <= 1'b1;
          r_state    <= c_WRITE;
        end
        c_WRITE: begin
          if (sram_ack) begin
            r_sram_req <= 1'b0;
            if (w_last) begin
              // Outcome flags are registered as FIN is entered, so busy
              // covers exactly the FETCH/LATCH/WRITE cycles of the copy.
              r_state <= c_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + 14'd1;
              r_rom_a <= r_idx + 14'd1;
              r_state <= c_FETCH;
            end
          end
        end
        c_FIN: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign rom_a    = r_rom_a;
  assign sram_a   = r_sram_a;
  assign sram_din = r_sram_din;
  assign sram_req = r_sram_req;
  assign busy     = r_busy;
  assign cpu_wait = r_busy;
  assign done     = r_done;
  assign aborted  = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_rom_shadow_copier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_shadow_copier
//  Purpose  : Directed self-checking bench for rom_shadow_copier. A main
//             instance (ROM_LEN=4, SRAM_BASE=0x1000) and a second instance
//             whose base sits two bytes below the top of the SRAM space.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_shadow_copier;

  logic        clk;
  logic        rst_n;

  // main instance
  logic        start;
  logic        abort;
  logic [13:0] rom_a;
  logic [7:0]  rom_dout;
  logic [20:0] sram_a;
  logic [7:0]  sram_din;
  logic        sram_req;
  logic        sram_ack;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        cpu_wait;

  // wrap instance
  logic        w_start;
  logic        w_abort;
  logic [13:0] w_rom_a;
  logic [7:0]  w_rom_dout;
  logic [20:0] w_sram_a;
  logic [7:0]  w_sram_din;
  logic        w_sram_req;
  logic        w_busy;
  logic        w_done;
  logic        w_aborted;
  logic        w_cpu_wait;

  int n_cmp = 0;
  int n_err = 0;

  // SRAM responder controls
  logic ack_block;
  logic slow_en;
  int   req_age;

  // scoreboard / monitor state
  logic [20:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          hold_q[$];
  logic [20:0] ww_q[$];
  int          busy_cnt;
  int          cw_bad;
  int          unstable;
  int          run_len;
  logic [20:0] prev_a;
  logic [7:0]  prev_d;

  // ROM contents seen by both instances: byte = addr ^ 0x5A
  logic [7:0] exp_d [4] = '{8'h5A, 8'h5B, 8'h58, 8'h59};
  logic [20:0] exp_wrap [4] = '{21'h1FFFFE, 21'h1FFFFF, 21'h000000, 21'h000001};

  rom_shadow_copier #(.ROM_LEN(4), .SRAM_BASE(21'h001000)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rom_a(rom_a), .rom_dout(rom_dout), .sram_a(sram_a), .sram_din(sram_din),
    .sram_req(sram_req), .sram_ack(sram_ack), .busy(busy), .done(done),
    .aborted(aborted), .cpu_wait(cpu_wait)
  );

  rom_shadow_copier #(.ROM_LEN(4), .SRAM_BASE(21'h1FFFFE)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort),
    .rom_a(w_rom_a), .rom_dout(w_rom_dout), .sram_a(w_sram_a), .sram_din(w_sram_din),
    .sram_req(w_sram_req), .sram_ack(w_sram_req), .busy(w_busy), .done(w_done),
    .aborted(w_aborted), .cpu_wait(w_cpu_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous ROMs, one-cycle read latency
  always @(posedge clk) begin
    rom_dout   <= 8'h5A ^ rom_a[7:0];
    w_rom_dout <= 8'h5A ^ w_rom_a[7:0];
  end

  // SRAM responder: byte at 0x1001 waits 3 extra cycles when slow_en is set
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_age <= 0;
    else if (sram_req && !sram_ack) req_age <= req_age + 1;
    else req_age <= 0;
  end
  assign sram_ack = sram_req && !ack_block &&
                    (req_age >= ((slow_en && sram_a == 21'h001001) ? 3 : 0));

  // monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (cpu_wait !== busy || w_cpu_wait !== w_busy) cw_bad++;
    if (sram_req) begin
      if (run_len > 0 && (sram_a !== prev_a || sram_din !== prev_d)) unstable++;
      run_len++;
      prev_a = sram_a;
      prev_d = sram_din;
      if (sram_ack) begin
        wa_q.push_back(sram_a);
        wd_q.push_back(sram_din);
        hold_q.push_back(run_len);
        run_len = 0;
      end
    end else begin
      run_len = 0;
    end
    if (w_sram_req) ww_q.push_back(w_sram_a);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    wa_q.delete();
    wd_q.delete();
    hold_q.delete();
    ww_q.delete();
    busy_cnt = 0;
    unstable = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, wa_q.size(), 4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      chk($sformatf("%s_a%0d", tag, i), {11'd0, wa_q[i]}, 32'h1000 + i);
      chk($sformatf("%s_d%0d", tag, i), {24'd0, wd_q[i]}, {24'd0, exp_d[i]});
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    w_start = 1'b0; w_abort = 1'b0;
    ack_block = 1'b0; slow_en = 1'b0;
    busy_cnt = 0; cw_bad = 0; unstable = 0; run_len = 0;
    prev_a = '0; prev_d = '0;

    // --- reset state ---
    repeat (3) @(negedge clk);
    chk("rst_rom_a", {18'd0, rom_a}, 0);
    chk("rst_sram_a", {11'd0, sram_a}, 0);
    chk("rst_sram_din", {24'd0, sram_din}, 0);
    chk("rst_flags", {27'd0, sram_req, busy, cpu_wait, done, aborted}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_rst", {30'd0, busy, sram_req}, 0);

    // --- basic copy on both instances ---
    clear_sb();
    @(posedge clk); #1 start = 1'b1; w_start = 1'b1;
    @(posedge clk); #1 start = 1'b0; w_start = 1'b0;
    wait_done("basic_done");
    check_writes("basic");
    chk("basic_busy_cyc", busy_cnt, 12);
    chk("basic_aborted", {31'd0, aborted}, 0);
    chk("basic_busy_end", {31'd0, busy}, 0);
    chk("wrap_done", {31'd0, w_done}, 1);
    chk("wrap_aborted", {31'd0, w_aborted}, 0);
    chk("wrap_nwr", ww_q.size(), 4);
    for (int i = 0; i < 4 && i < ww_q.size(); i++)
      chk($sformatf("wrap_a%0d", i), {11'd0, ww_q[i]}, {11'd0, exp_wrap[i]});

    // --- delayed ack on byte 1 ---
    clear_sb();
    slow_en = 1'b1;
    pulse_start();
    wait_done("slow_done");
    slow_en = 1'b0;
    check_writes("slow");
    if (hold_q.size() == 4) begin
      chk("slow_hold0", hold_q[0], 1);
      chk("slow_hold1", hold_q[1], 4);
    end else begin
      chk("slow_hold_n", hold_q.size(), 4);
    end
    chk("slow_stable", unstable, 0);
    chk("slow_busy_cyc", busy_cnt, 15);

    // --- abort during LATCH of byte 2 ---
    clear_sb();
    pulse_start();
    k = 0;
    while (rom_a != 14'd2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach_b2", {18'd0, rom_a}, 2);
    @(posedge clk); #1 abort = 1'b1;   // now in LATCH
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_aborted", {31'd0, aborted}, 1);
    chk("abort_done", {31'd0, done}, 0);
    repeat (5) @(negedge clk);
    chk("abort_nwr", wa_q.size(), 2);
    chk("abort_req", {31'd0, sram_req}, 0);

    // --- start with abort held in IDLE is ignored ---
    abort = 1'b1;
    pulse_start();
    repeat (2) @(negedge clk);
    chk("start_w_abort_busy", {31'd0, busy}, 0);
    chk("start_w_abort_flag", {31'd0, aborted}, 1);
    abort = 1'b0;

    // --- start while busy ignored, then restart after done ---
    clear_sb();
    pulse_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("rebusy_done");
    check_writes("rebusy");
    chk("rebusy_busy_cyc", busy_cnt, 12);
    chk("rebusy_aborted", {31'd0, aborted}, 0);
    clear_sb();
    pulse_start();
    @(negedge clk);
    chk("restart_done_clr", {31'd0, done}, 0);
    chk("restart_busy", {31'd0, busy}, 1);
    wait_done("restart_done");
    check_writes("restart");

    // --- reset while a write is pending ---
    clear_sb();
    ack_block = 1'b1;
    pulse_start();
    k = 0;
    while (!sram_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rstw_req_seen", {31'd0, sram_req}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_req", {31'd0, sram_req}, 0);
    chk("rstw_flags", {28'd0, busy, cpu_wait, done, aborted}, 0);
    chk("rstw_addr", {11'd0, sram_a}, 0);
    chk("rstw_rom_a", {18'd0, rom_a}, 0);
    chk("rstw_din", {24'd0, sram_din}, 0);
    @(negedge clk);
    ack_block = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstw_nwr", wa_q.size(), 0);
    chk("rstw_idle", {31'd0, busy}, 0);
    pulse_start();
    wait_done("rstw_done");
    check_writes("rstw");

    chk("cpu_wait_eq_busy", cw_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
